// File: rtl/snow_v_lfsr_pkg.sv
// Shared types and GF(2^16) constants for the SNOW-V LFSR pair.
package snow_v_lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int unsigned WORD_W = 16;

    localparam logic [15:0] MUL_A_POLY = 16'h990F;
    localparam logic [15:0] INV_A_POLY = 16'hCC87;
    localparam logic [15:0] MUL_B_POLY = 16'hC963;
    localparam logic [15:0] INV_B_POLY = 16'hE4B1;

    // Multiply by x, reducing by the field polynomial when the top bit falls out.
    function automatic logic [15:0] gf_mul(input logic [15:0] v, input logic [15:0] poly);
        return {v[14:0], 1'b0} ^ (v[15] ? poly : 16'h0000);
    endfunction

    function automatic logic [15:0] gf_inv(input logic [15:0] v, input logic [15:0] poly);
        return {1'b0, v[15:1]} ^ (v[0] ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/snow_v_lfsr_step.sv
// One 8-word parallel step of both LFSRs; word i of a bus lives at [16i+15:16i].
module snow_v_lfsr_step
    import snow_v_lfsr_pkg::*;
(
    input  logic [255:0] a,
    input  logic [255:0] b,
    output logic [255:0] a_next,
    output logic [255:0] b_next
);

    always_comb begin
        // Upper halves shift down; the eight new words fill the top.
        a_next = {128'b0, a[255:128]};
        b_next = {128'b0, b[255:128]};
        for (int unsigned j = 0; j < 8; j++) begin
            a_next[128 + WORD_W*j +: WORD_W] = b[WORD_W*j +: WORD_W]
                ^ gf_mul(a[WORD_W*j +: WORD_W], MUL_A_POLY)
                ^ a[WORD_W*(j+1) +: WORD_W]
                ^ gf_inv(a[WORD_W*(j+8) +: WORD_W], INV_A_POLY);
            b_next[128 + WORD_W*j +: WORD_W] = a[WORD_W*j +: WORD_W]
                ^ gf_mul(b[WORD_W*j +: WORD_W], MUL_B_POLY)
                ^ b[WORD_W*(j+3) +: WORD_W]
                ^ gf_inv(b[WORD_W*(j+8) +: WORD_W], INV_B_POLY);
        end
    end

endmodule

// File: rtl/snow_v_lfsr.sv
// SNOW-V LFSR-A/LFSR-B register pair with IDLE/INIT/RUN sequencing and FSM feedback hooks.
module snow_v_lfsr #(
    parameter int INIT_ROUNDS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [127:0] iv,
    input  logic [127:0] z_in,
    input  logic         ks_en,
    output logic [127:0] t1,
    output logic [127:0] t2,
    output logic         busy,
    output logic         ks_valid,
    output logic [1:0]   r1_mix,
    output logic         init_done
);
    import snow_v_lfsr_pkg::*;

    localparam int CNT_W = (INIT_ROUNDS > 1) ? $clog2(INIT_ROUNDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(INIT_ROUNDS - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(INIT_ROUNDS - 2);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [255:0]       a_q, b_q, a_nx, b_nx, a_step, b_step;
    logic               done_q, done_nx;

    snow_v_lfsr_step u_step (
        .a      (a_q),
        .b      (b_q),
        .a_next (a_step),
        .b_next (b_step)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        a_nx     = a_q;
        b_nx     = b_q;
        done_nx  = 1'b0;
        if (start) begin
            a_nx     = {key[127:0], iv};
            b_nx     = {key[255:128], 128'b0};
            cnt_nx   = '0;
            state_nx = INIT;
        end else begin
            case (state)
                INIT: begin
                    a_nx = a_step ^ {z_in, 128'b0};
                    b_nx = b_step;
                    if (cnt == CNT_LAST) begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                        done_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (ks_en) begin
                        a_nx = a_step;
                        b_nx = b_step;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            a_q    <= a_nx;
            b_q    <= b_nx;
            done_q <= done_nx;
        end
    end

    assign t1        = b_q[255:128];
    assign t2        = a_q[127:0];
    assign busy      = (state == INIT);
    assign ks_valid  = (state == RUN);
    assign init_done = done_q;

    always_comb begin
        r1_mix = 2'b00;
        if (state == INIT && cnt == CNT_PENULT)
            r1_mix = 2'b01;
        else if (state == INIT && cnt == CNT_LAST)
            r1_mix = 2'b10;
    end

endmodule

// File: tb/tb_snow_v_lfsr.sv
// Bench for snow_v_lfsr: word-list reference model driven alongside random and directed stimulus.
module tb_snow_v_lfsr;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst, start, ks_en;
    logic [255:0] key;
    logic [127:0] iv, z_in, t1, t2;
    logic         busy, ks_valid, init_done;
    logic [1:0]   r1_mix;

    always #5 clk = ~clk;

    snow_v_lfsr #(.INIT_ROUNDS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .iv        (iv),
        .z_in      (z_in),
        .ks_en     (ks_en),
        .t1        (t1),
        .t2        (t2),
        .busy      (busy),
        .ks_valid  (ks_valid),
        .r1_mix    (r1_mix),
        .init_done (init_done)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] ma [16];
    logic [15:0] mb [16];
    int          mstate;   // 0 idle, 1 init, 2 run
    int          mcnt;
    bit          mdone;

    function automatic logic [15:0] mul_x(input logic [15:0] v, input logic [15:0] poly);
        int r;
        r = int'(v) * 2;
        if (r >= 65536) r = (r - 65536) ^ int'(poly);
        return 16'(r);
    endfunction

    function automatic logic [15:0] div_x(input logic [15:0] v, input logic [15:0] poly);
        int r;
        r = int'(v) / 2;
        if ((int'(v) % 2) == 1) r = r ^ int'(poly);
        return 16'(r);
    endfunction

    task automatic model_step();
        logic [15:0] ea [24];
        logic [15:0] eb [24];
        for (int i = 0; i < 16; i++) begin
            ea[i] = ma[i];
            eb[i] = mb[i];
        end
        for (int j = 0; j < 8; j++) begin
            ea[16+j] = mb[j] ^ mul_x(ma[j], 16'h990F) ^ ma[j+1] ^ div_x(ma[j+8], 16'hCC87);
            eb[16+j] = ma[j] ^ mul_x(mb[j], 16'hC963) ^ mb[j+3] ^ div_x(mb[j+8], 16'hE4B1);
        end
        for (int i = 0; i < 16; i++) begin
            ma[i] = ea[i+8];
            mb[i] = eb[i+8];
        end
    endtask

    task automatic model_update();
        mdone = 1'b0;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                ma[i] = 16'h0;
                mb[i] = 16'h0;
            end
            mstate = 0;
            mcnt   = 0;
        end else if (start) begin
            for (int i = 0; i < 8; i++) begin
                ma[8+i] = key[16*i +: 16];
                ma[i]   = iv[16*i +: 16];
                mb[8+i] = key[128 + 16*i +: 16];
                mb[i]   = 16'h0;
            end
            mstate = 1;
            mcnt   = 0;
        end else if (mstate == 1) begin
            model_step();
            for (int i = 0; i < 8; i++) ma[8+i] = ma[8+i] ^ z_in[16*i +: 16];
            if (mcnt == N - 1) begin
                mstate = 2;
                mcnt   = 0;
                mdone  = 1'b1;
            end else begin
                mcnt++;
            end
        end else if (mstate == 2 && ks_en) begin
            model_step();
        end
    endtask

    function automatic logic [255:0] pack_a();
        logic [255:0] r;
        for (int i = 0; i < 16; i++) r[16*i +: 16] = ma[i];
        return r;
    endfunction

    function automatic logic [255:0] pack_b();
        logic [255:0] r;
        for (int i = 0; i < 16; i++) r[16*i +: 16] = mb[i];
        return r;
    endfunction

    function automatic logic [127:0] exp_t1();
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[16*i +: 16] = mb[8+i];
        return r;
    endfunction

    function automatic logic [127:0] exp_t2();
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[16*i +: 16] = ma[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [1:0] er;
        er = 2'b00;
        if (mstate == 1 && mcnt == N - 2) er = 2'b01;
        else if (mstate == 1 && mcnt == N - 1) er = 2'b10;
        chk({tag, ".t1"},        256'(t1),        256'(exp_t1()));
        chk({tag, ".t2"},        256'(t2),        256'(exp_t2()));
        chk({tag, ".busy"},      256'(busy),      256'(mstate == 1));
        chk({tag, ".ks_valid"},  256'(ks_valid),  256'(mstate == 2));
        chk({tag, ".r1_mix"},    256'(r1_mix),    256'(er));
        chk({tag, ".init_done"}, 256'(init_done), 256'(mdone));
        chk({tag, ".a"},         dut.a_q,         pack_a());
        chk({tag, ".b"},         dut.b_q,         pack_b());
    endtask

    task automatic cycle();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_key_iv();
        for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom();
        for (int i = 0; i < 4; i++) iv[32*i +: 32] = $urandom();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy_cycles;
        int done_pulses;
        int pat [4];

        rst = 1'b1; start = 1'b0; ks_en = 1'b0;
        key = '0; iv = '0; z_in = '0;
        @(negedge clk);
        cycle();
        cycle();
        check_all("reset");
        chk("reset.t1z", 256'(t1), 256'(0));
        chk("reset.t2z", 256'(t2), 256'(0));

        rst = 1'b0;
        cycle();
        cycle();
        check_all("idle");

        // Directed single-bit key
        key = 256'h1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check_all("load");
        chk("load.t2z", 256'(t2), 256'(0));
        chk("load.t1z", 256'(t1), 256'(0));
        cycle();
        check_all("step1");
        chk("step1.a0", 256'(t2[15:0]), 256'(16'h0001));
        chk("step1.a8", 256'(dut.a_q[143:128]), 256'(16'hCC87));
        chk("step1.t1z", 256'(t1), 256'(0));
        cycle();
        check_all("step2");
        chk("step2.a8", 256'(dut.a_q[143:128]), 256'(16'hAAC6));
        chk("step2.b8", 256'(t1[15:0]), 256'(16'h0001));

        // Full init with all-ones feedback
        rand_key_iv();
        z_in = '1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        busy_cycles = 0;
        done_pulses = 0;
        for (int k = 0; k < 40 && busy; k++) begin
            busy_cycles++;
            check_all("init");
            if (k == 14) chk("init.r1_c14", 256'(r1_mix), 256'(2'b01));
            if (k == 15) chk("init.r1_c15", 256'(r1_mix), 256'(2'b10));
            cycle();
            if (init_done) done_pulses++;
        end
        check_all("run_entry");
        chk("init.busy_cycles", 256'(busy_cycles), 256'(N));
        ks_en = 1'b0;
        cycle();
        if (init_done) done_pulses++;
        check_all("run_hold0");
        chk("init.done_pulses", 256'(done_pulses), 256'(1));

        // ks_en pattern; z_in must be ignored in RUN
        pat = '{1, 0, 0, 1};
        for (int k = 0; k < 4; k++) begin
            ks_en = pat[k][0];
            z_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            cycle();
            check_all("run_pat");
        end
        for (int k = 0; k < 20; k++) begin
            ks_en = $urandom_range(0, 1) == 1;
            cycle();
            check_all("run_rand");
        end

        // Restart while INIT is at count 7
        ks_en = 1'b0;
        z_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        rand_key_iv();
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cycle();
            check_all("pre_restart");
        end
        chk("pre_restart.cnt", 256'(dut.cnt), 256'(7));
        rand_key_iv();
        start = 1'b1;
        cycle();
        start = 1'b0;
        check_all("reload");
        chk("reload.cnt", 256'(dut.cnt), 256'(0));
        busy_cycles = 0;
        for (int k = 0; k < 40 && busy; k++) begin
            busy_cycles++;
            z_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            check_all("reinit");
            cycle();
        end
        chk("reinit.busy_cycles", 256'(busy_cycles), 256'(N));
        check_all("rerun");

        // Asynchronous reset in RUN
        ks_en = 1'b1;
        cycle();
        cycle();
        check_all("pre_rst");
        rst = 1'b1;
        #1;
        model_update();
        check_all("async_rst");
        chk("async_rst.t1z", 256'(t1), 256'(0));
        chk("async_rst.t2z", 256'(t2), 256'(0));
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_all("post_rst");
        end
        chk("post_rst.ks_valid", 256'(ks_valid), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
